vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen_if.sv | 21 ++
 rtl/vga_pattern_gen.sv | 124 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel request/response bundle between the VGA timing driver and the
// pattern source. The driver owns coordinates, sync and mode select; the
// pattern source returns colour and the frame tick.
interface vga_pattern_gen_if;
  logic [1:0]  mode;
  logic        vs;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [23:0] pixel_data;
  logic        frame_tick;

  modport master (
    output mode, vs, pixel_x, pixel_y,
    input  pixel_data, frame_tick
  );

  modport slave (
    input  mode, vs, pixel_x, pixel_y,
    output pixel_data, frame_tick
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: colour bars, checkerboard, bouncing box and a
// grey time ramp. Colour is returned one clock after the coordinate request.
// Frame state (mode, frame counter, box) only moves on the vs falling edge.
module vga_pattern_gen #(
  parameter int          H_DISP    = 640,
  parameter int          V_DISP    = 480,
  parameter int          Y_MIN     = 1,
  parameter int          BOX_SIZE  = 64,
  parameter int          STEP      = 2,
  parameter logic [23:0] BOX_COLOR = 24'hFFFFFF
) (
  input  logic            clk,
  input  logic            rst,
  vga_pattern_gen_if.slave vid
);

  localparam int          BAR_W  = H_DISP / 8;
  localparam logic [9:0]  Y_LO   = 10'(Y_MIN);
  localparam logic [9:0]  Y_HI   = 10'(Y_MIN + V_DISP);
  localparam logic [9:0]  X_HI   = 10'(H_DISP);
  localparam logic [10:0] XMAX   = 11'(H_DISP - BOX_SIZE);
  localparam logic [10:0] YMAX   = 11'(V_DISP - BOX_SIZE);
  localparam logic [10:0] BOX_L  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_L = 11'(STEP);

  // One axis of the box walk: returns {dir_neg, position}. The box clamps
  // to the wall and reverses instead of overshooting it.
  function automatic logic [11:0] step_axis(input logic [10:0] pos,
                                            input logic        neg,
                                            input logic [10:0] lim);
    if (!neg) begin
      if (pos + STEP_L >= lim) return {1'b1, lim};
      else                     return {1'b0, pos + STEP_L};
    end else begin
      if (pos <= STEP_L)       return {1'b0, 11'd0};
      else                     return {1'b1, pos - STEP_L};
    end
  endfunction

  logic        vs_d;
  logic        vs_seen;
  logic        tick;
  logic [1:0]  mode_q;
  logic [7:0]  frame_cnt;
  logic [10:0] box_x;
  logic [10:0] box_y;
  logic        dir_x_neg;
  logic        dir_y_neg;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        active;
  logic [2:0]  bar;
  logic        in_box;
  logic [23:0] colour;
  logic [23:0] pixel_p1;

  // vs must be seen high after reset before a fall counts, so a vs that is
  // already low when reset releases never produces a spurious tick.
  assign tick           = vs_d & ~vid.vs & vs_seen & ~rst;
  assign vid.frame_tick = tick;
  assign vid.pixel_data = pixel_p1;

  // Stage p0: decode the requested coordinate into a colour.
  always_comb begin
    col    = vid.pixel_x;
    row    = vid.pixel_y - Y_LO;
    active = (vid.pixel_y >= Y_LO) && (vid.pixel_y < Y_HI) && (vid.pixel_x < X_HI);
    bar    = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (col >= 10'(k * BAR_W)) bar = bar + 3'd1;
    end
    in_box = ({1'b0, col} >= box_x) && ({1'b0, col} < box_x + BOX_L) &&
             ({1'b0, row} >= box_y) && ({1'b0, row} < box_y + BOX_L);
    colour = 24'h000000;
    case (mode_q)
      2'd0: begin
        case (bar)
          3'd0:    colour = 24'hFFFFFF;
          3'd1:    colour = 24'hFFFF00;
          3'd2:    colour = 24'h00FFFF;
          3'd3:    colour = 24'h00FF00;
          3'd4:    colour = 24'hFF00FF;
          3'd5:    colour = 24'hFF0000;
          3'd6:    colour = 24'h0000FF;
          default: colour = 24'h000000;
        endcase
      end
      2'd1:    colour = (col[5] ^ row[5] ^ frame_cnt[5]) ? 24'hFFFFFF : 24'h000000;
      2'd2:    colour = in_box ? BOX_COLOR : {col[9:2], row[8:1], frame_cnt};
      default: colour = {frame_cnt, frame_cnt, frame_cnt};
    endcase
    if (!active) colour = 24'h000000;
  end

  // Stage p1: register the colour for the driver.
  always_ff @(posedge clk) begin
    if (rst) pixel_p1 <= 24'h000000;
    else     pixel_p1 <= colour;
  end

  // Frame-level state: sync edge tracking, then mode/counter/box on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d      <= 1'b1;
      vs_seen   <= 1'b0;
      mode_q    <= 2'd0;
      frame_cnt <= 8'd0;
      box_x     <= 11'd0;
      box_y     <= 11'd0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
    end else begin
      vs_d <= vid.vs;
      if (vid.vs) vs_seen <= 1'b1;
      if (tick) begin
        mode_q                <= vid.mode;
        frame_cnt             <= frame_cnt + 8'd1;
        {dir_x_neg, box_x}    <= step_axis(box_x, dir_x_neg, XMAX);
        {dir_y_neg, box_y}    <= step_axis(box_y, dir_y_neg, YMAX);
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: random pixel requests and frame sync against a
// plain-arithmetic picture model, plus directed boundary requests.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_pattern_gen_if bus();

  vga_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .vid (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference picture state
  int m_mode = 0, m_fc = 0, m_bx = 0, m_by = 0, m_vx = 2, m_vy = 2;
  bit m_last_vs = 1'b1, m_armed = 1'b0;
  logic [23:0] exp_pd = 24'h0;

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [23:0] ref_pix(int x, int y, int m, int fc, int bx, int by);
    int c, r;
    if (y < 1 || y > 480 || x >= 640) return 24'h0;
    c = x;
    r = y - 1;
    case (m)
      0: begin
        case (c / 80)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return (((c / 32) + (r / 32) + (fc / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      2: begin
        if (c >= bx && c < bx + 64 && r >= by && r < by + 64) return 24'hFFFFFF;
        return {8'(c / 4), 8'(r / 2), 8'(fc)};
      end
      default: return {8'(fc), 8'(fc), 8'(fc)};
    endcase
  endfunction

  task automatic move(inout int p, inout int v, input int lim);
    int n;
    n = p + v;
    if (v > 0 && n >= lim)     begin p = lim; v = -2; end
    else if (v < 0 && n <= 0)  begin p = 0;   v = 2;  end
    else p = n;
  endtask

  // One clock: check outputs at negedge, predict, advance model at posedge.
  task automatic cyc();
    bit t;
    @(negedge clk);
    check_eq("pixel_data", bus.pixel_data, exp_pd);
    t = !rst && m_armed && m_last_vs && !bus.vs;
    check_eq("frame_tick", {23'b0, bus.frame_tick}, {23'b0, t});
    exp_pd = rst ? 24'h0 : ref_pix(int'(bus.pixel_x), int'(bus.pixel_y), m_mode, m_fc, m_bx, m_by);
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_vx = 2; m_vy = 2;
      m_last_vs = 1'b1; m_armed = 1'b0;
    end else begin
      if (t) begin
        m_mode = int'(bus.mode);
        m_fc   = (m_fc + 1) % 256;
        move(m_bx, m_vx, 576);
        move(m_by, m_vy, 416);
      end
      if (bus.vs) m_armed = 1'b1;
      m_last_vs = bus.vs;
    end
    #1;
  endtask

  task automatic req(input int x, input int y);
    bus.pixel_x = 10'(x);
    bus.pixel_y = 10'(y);
    cyc();
  endtask

  task automatic rand_req();
    bus.pixel_x = 10'($urandom_range(0, 700));
    bus.pixel_y = 10'($urandom_range(0, 500));
    cyc();
  endtask

  // A short frame: random requests and mode noise while vs is high, then
  // one vs-low cycle that latches mode m.
  task automatic tick_frame(input logic [1:0] m);
    bus.vs = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      bus.mode = 2'($urandom_range(0, 3));
      rand_req();
    end
    bus.mode = m;
    bus.vs   = 1'b0;
    rand_req();
  endtask

  initial begin
    bus.mode = 2'd0; bus.vs = 1'b0; bus.pixel_x = 10'd0; bus.pixel_y = 10'd1;
    @(posedge clk);
    #1;

    // Reset with vs low and an active request
    repeat (3) cyc();
    check_eq("rst_pd", bus.pixel_data, 24'h0);
    rst = 1'b0;
    bus.mode = 2'd3;
    repeat (3) req(0, 1);
    check_eq("rst_no_tick", {23'b0, bus.frame_tick}, 24'h0);
    tick_frame(2'd3);
    req(0, 1);
    check_eq("first_fc", bus.pixel_data, 24'h010101);

    // Colour bars and inactive requests
    tick_frame(2'd0);
    req(0, 1);     check_eq("bar0_l", bus.pixel_data, 24'hFFFFFF);
    req(79, 1);    check_eq("bar0_r", bus.pixel_data, 24'hFFFFFF);
    req(80, 1);    check_eq("bar1_l", bus.pixel_data, 24'hFFFF00);
    req(639, 480); check_eq("bar7_end", bus.pixel_data, 24'h000000);
    req(559, 1);   check_eq("bar6_r", bus.pixel_data, 24'h0000FF);
    req(0, 0);     check_eq("inact_y0", bus.pixel_data, 24'h0);
    req(640, 5);   check_eq("inact_x640", bus.pixel_data, 24'h0);

    // Mode change away from a tick waits for the next tick
    bus.mode = 2'd1;
    req(100, 1);   check_eq("mc_hold0", bus.pixel_data, 24'hFFFF00);
    bus.vs = 1'b1;
    req(100, 1);   check_eq("mc_hold1", bus.pixel_data, 24'hFFFF00);
    bus.vs = 1'b0;
    req(100, 1);   check_eq("mc_tick_cycle", bus.pixel_data, 24'hFFFF00);
    req(100, 1);   check_eq("mc_chk_a", bus.pixel_data, 24'hFFFFFF);
    req(32, 1);    check_eq("mc_chk_b", bus.pixel_data, 24'hFFFFFF);
    req(0, 1);     check_eq("mc_chk_c", bus.pixel_data, 24'h000000);
    req(64, 33);   check_eq("mc_chk_d", bus.pixel_data, 24'hFFFFFF);

    // Mid-operation reset, then three ticks in box mode
    rst = 1'b1;
    req(0, 1);     check_eq("midrst_pd", bus.pixel_data, 24'h0);
    rst = 1'b0;
    repeat (3) tick_frame(2'd2);
    req(6, 7);     check_eq("box_corner", bus.pixel_data, 24'hFFFFFF);
    req(70, 7);    check_eq("box_right_out", bus.pixel_data, 24'h110303);
    req(5, 7);     check_eq("box_left_out", bus.pixel_data, 24'h010303);
    req(69, 70);   check_eq("box_far_corner", bus.pixel_data, 24'hFFFFFF);
    req(69, 71);   check_eq("box_below", bus.pixel_data, 24'h112303);

    // Long random run through the bounces and the counter wrap
    for (int k = 4; k <= 289; k++) begin
      logic [1:0] m;
      if (k == 255 || k == 256) m = 2'd3;
      else if (k >= 288)        m = 2'd2;
      else                      m = 2'($urandom_range(0, 3));
      tick_frame(m);
      if (k == 255) begin
        req(0, 1);     check_eq("fc255", bus.pixel_data, 24'hFFFFFF);
      end
      if (k == 256) begin
        req(0, 1);     check_eq("fc_wrap", bus.pixel_data, 24'h000000);
      end
      if (k == 288) begin
        req(576, 257); check_eq("bx576_in", bus.pixel_data, 24'hFFFFFF);
        req(639, 257); check_eq("bx576_edge", bus.pixel_data, 24'hFFFFFF);
        req(575, 257); check_eq("bx576_left", bus.pixel_data, 24'h8F8020);
        req(576, 256); check_eq("by256_above", bus.pixel_data, 24'h907F20);
      end
      if (k == 289) begin
        req(574, 255); check_eq("bx574_in", bus.pixel_data, 24'hFFFFFF);
        req(573, 255); check_eq("bx574_left", bus.pixel_data, 24'h8F7F21);
        req(638, 255); check_eq("bx574_right", bus.pixel_data, 24'h9F7F21);
      end
    end
    repeat (2) rand_req();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
